// File: rtl/acc_pkg.sv
// acc_pkg: state type, address map and register bit positions for the accelerator sequencer
package acc_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} acc_state_e;
    localparam logic [11:0] CTRL_ADDR   = 12'h000;
    localparam logic [11:0] STATUS_ADDR = 12'h001;
    localparam logic [11:0] A_BASE      = 12'h400;
    localparam logic [11:0] B_BASE      = 12'h800;
    localparam logic [11:0] C_BASE      = 12'hC00;
    localparam int ST_BUSY = 0, ST_DONE = 1, ST_TMO = 2, ST_ERR = 3, ST_CNT = 16;
    localparam int CTRL_START = 0, CTRL_CLEAR = 1;
endpackage

// File: rtl/acc_seq_ctrl_if.sv
// acc_seq_ctrl_if: word bus between a host and the accelerator sequencer
interface acc_seq_ctrl_if #(parameter int ADDR_W = 12);
    logic              bus_req;
    logic              bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [31:0]       bus_wdata;
    logic              bus_gnt;
    logic              bus_rvalid;
    logic [31:0]       bus_rdata;
    modport master (output bus_req, bus_we, bus_addr, bus_wdata, input bus_gnt, bus_rvalid, bus_rdata);
    modport slave  (input bus_req, bus_we, bus_addr, bus_wdata, output bus_gnt, bus_rvalid, bus_rdata);
endinterface

// File: rtl/acc_run_timer.sv
// acc_run_timer: counts RUN cycles (saturating at 16 bits) and flags the cycle that hits TIMEOUT
module acc_run_timer #(
    parameter int TIMEOUT = 65535
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        en,
    output logic        tmo,
    output logic [15:0] count
);
    // count holds completed cycles, so the current RUN cycle number is count+1
    assign tmo = en && ({1'b0, count} + 17'd1 >= 17'(TIMEOUT));
    always_ff @(posedge clk)
        if (rst || clr) count <= '0;
        else if (en && count != 16'hFFFF) count <= count + 16'd1;
endmodule

// File: rtl/acc_seq_ctrl.sv
// acc_seq_ctrl: bus decode, operand/result buffer strobes and IDLE/RUN/DONE run handshake
module acc_seq_ctrl
    import acc_pkg::*;
#(
    parameter int N_ELEM  = 1024,
    parameter int ADDR_W  = 12,
    parameter int TIMEOUT = 65535,
    localparam int IDX_W  = $clog2(N_ELEM)
) (
    input  logic             clk,
    input  logic             rst,
    acc_seq_ctrl_if.slave    bus,
    output logic             buf_a_we,
    output logic             buf_b_we,
    output logic             buf_c_re,
    output logic [IDX_W-1:0] buf_idx,
    output logic [7:0]       buf_wdata,
    input  logic [7:0]       buf_c_rdata,
    output logic             acc_start,
    input  logic             acc_done,
    output logic             irq
);
    acc_state_e  state, state_n;
    logic        done, tmo, err, done_n, tmo_n, err_n, c_pend, t_tmo, hit;
    logic        rd, wr, ctrl_wr, running, go, wipe, c_rd, ab_wr;
    logic [1:0]  rgn;
    logic [15:0] cnt;
    logic [31:0] status, rdata_q;

    assign bus.bus_gnt   = bus.bus_req;
    assign rgn           = bus.bus_addr[ADDR_W-1 -: 2];
    assign rd            = bus.bus_req && !bus.bus_we;
    assign wr            = bus.bus_req && bus.bus_we;
    assign ctrl_wr       = wr && bus.bus_addr == CTRL_ADDR;
    assign running       = state == RUN;
    assign go            = ctrl_wr && bus.bus_wdata[CTRL_START] && !bus.bus_wdata[CTRL_CLEAR] && !running;
    assign wipe          = ctrl_wr && bus.bus_wdata[CTRL_CLEAR] && !running;
    assign c_rd          = rd && rgn == C_BASE[11:10];
    assign ab_wr         = wr && (rgn == A_BASE[11:10] || rgn == B_BASE[11:10]);
    assign buf_a_we      = wr && rgn == A_BASE[11:10] && !running;
    assign buf_b_we      = wr && rgn == B_BASE[11:10] && !running;
    assign buf_c_re      = c_rd && state == DONE;
    assign buf_idx       = bus.bus_addr[IDX_W-1:0];
    assign buf_wdata     = bus.bus_wdata[7:0];
    assign hit           = running && (acc_done || t_tmo);
    assign bus.bus_rdata = c_pend ? {24'd0, buf_c_rdata} : rdata_q;

    acc_run_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk(clk), .rst(rst), .clr(go || wipe), .en(running), .tmo(t_tmo), .count(cnt)
    );

    always_comb begin
        state_n = running ? (hit ? DONE : RUN) : wipe ? IDLE : go ? RUN : state;
        done_n  = (running && acc_done) || (done && !go && !wipe);
        tmo_n   = (running && t_tmo && !acc_done) || (tmo && !go && !wipe);
        // control writes and operand writes during a run, and C reads outside DONE, are refused
        err_n   = !wipe && (err || (running && ((ctrl_wr && (bus.bus_wdata[CTRL_START] || bus.bus_wdata[CTRL_CLEAR])) || ab_wr)) || (c_rd && !buf_c_re));
        status  = '0;
        status[ST_BUSY] = running;
        status[ST_DONE] = done;
        status[ST_TMO]  = tmo;
        status[ST_ERR]  = err;
        status[ST_CNT +: 16] = cnt;
    end

    always_ff @(posedge clk)
        if (rst) begin
            state <= IDLE;
            done <= 1'b0;
            tmo <= 1'b0;
            err <= 1'b0;
            acc_start <= 1'b0;
            irq <= 1'b0;
            bus.bus_rvalid <= 1'b0;
            c_pend <= 1'b0;
            rdata_q <= '0;
        end else begin
            state <= state_n;
            done <= done_n;
            tmo <= tmo_n;
            err <= err_n;
            acc_start <= go;
            irq <= hit;
            bus.bus_rvalid <= rd;
            c_pend <= buf_c_re;
            rdata_q <= (rd && bus.bus_addr == STATUS_ADDR) ? status : '0;
        end
endmodule
